// File: rtl/moving_average_ring.sv
// Ring-buffer moving average over a selectable power-of-two window.
// A running sum is updated per accepted sample, and the output is rounded half up and registered.
module moving_average_ring #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_LOG2   = 4,
  parameter int WSEL_W     = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic        [WSEL_W-1:0]     win_log2,
  input  logic                         out_mode,
  output logic signed [DATA_WIDTH-1:0] dout,
  output logic                         out_valid,
  output logic                         filling
);

  localparam int DEPTH = 1 << MAX_LOG2;
  localparam int SW    = DATA_WIDTH + MAX_LOG2;
  localparam int CW    = MAX_LOG2 + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam logic [WSEL_W-1:0] WIN_MAX = WSEL_W'(MAX_LOG2);

  logic        [DATA_WIDTH-1:0] r_buf [DEPTH];
  logic        [MAX_LOG2-1:0]   r_wptr;
  logic signed [SW-1:0]         r_sum;
  logic        [CW-1:0]         r_count;
  logic        [CW-1:0]         r_dec;
  logic        [1:0]            r_state;
  logic        [WSEL_W-1:0]     r_win;
  logic signed [DATA_WIDTH-1:0] r_dout;
  logic                         r_out_valid;

  logic        [WSEL_W-1:0]     w_win_sel;
  logic        [CW-1:0]         w_n;
  logic                         w_flush;
  logic                         w_accept;
  logic        [MAX_LOG2-1:0]   w_rd;
  logic signed [SW-1:0]         w_din_ext;
  logic signed [SW-1:0]         w_old;
  logic signed [SW-1:0]         w_sum_next;
  logic        [CW-1:0]         w_cnt_inc;
  logic        [CW-1:0]         w_dec_inc;
  logic                         w_enter_run;
  logic                         w_dec_wrap;
  logic                         w_strobe;
  logic signed [SW:0]           w_rnd;
  logic signed [DATA_WIDTH-1:0] w_avg;

  always_comb begin
    w_win_sel   = (win_log2 > WIN_MAX) ? WIN_MAX : win_log2;
    w_n         = CW'(1) << r_win;
    w_flush     = enable & (clear | (w_win_sel != r_win));
    w_accept    = enable & in_valid & ~w_flush;
    // Entry written N accepts ago; when N == DEPTH this is the slot about to be overwritten.
    w_rd        = r_wptr - w_n[MAX_LOG2-1:0];
    w_din_ext   = {{MAX_LOG2{din[DATA_WIDTH-1]}}, din};
    w_old       = '0;
    if (r_state == S_RUN)
      w_old = {{MAX_LOG2{r_buf[w_rd][DATA_WIDTH-1]}}, r_buf[w_rd]};
    w_sum_next  = r_sum + w_din_ext - w_old;
    w_cnt_inc   = r_count + 1'b1;
    w_dec_inc   = r_dec + 1'b1;
    w_enter_run = (r_state != S_RUN) && (w_cnt_inc == w_n);
    w_dec_wrap  = (w_dec_inc == w_n);
    w_strobe    = w_enter_run | ((r_state == S_RUN) & (~out_mode | w_dec_wrap));
    w_rnd       = {w_sum_next[SW-1], w_sum_next} + {{DATA_WIDTH{1'b0}}, (w_n >> 1)};
    w_avg       = DATA_WIDTH'(w_rnd >>> r_win);
  end

  always_ff @(posedge clk) begin
    if (w_accept)
      r_buf[r_wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_sum       <= '0;
      r_count     <= '0;
      r_dec       <= '0;
      r_state     <= S_IDLE;
      r_win       <= '0;
      r_dout      <= '0;
      r_out_valid <= 1'b0;
    end else if (w_flush) begin
      r_win       <= w_win_sel;
      r_sum       <= '0;
      r_count     <= '0;
      r_dec       <= '0;
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_wptr      <= r_wptr + 1'b1;
      r_sum       <= w_sum_next;
      r_out_valid <= w_strobe;
      if (w_strobe)
        r_dout <= w_avg;
      if (w_enter_run) begin
        r_state <= S_RUN;
        r_count <= w_cnt_inc;
        r_dec   <= '0;
      end else if (r_state == S_RUN) begin
        r_dec <= w_dec_wrap ? '0 : w_dec_inc;
      end else begin
        r_state <= S_FILL;
        r_count <= w_cnt_inc;
      end
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign dout      = r_dout;
  assign out_valid = r_out_valid;
  assign filling   = (r_state != S_RUN);

endmodule

// File: tb/tb_moving_average_ring.sv
// Directed and randomized bench for moving_average_ring.
// The reference model keeps the accepted samples and averages the newest N of them.
module tb_moving_average_ring;

  localparam int DW = 16;
  localparam int ML = 4;
  localparam int WW = 3;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 enable = 1'b0;
  logic                 clear = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 out_mode = 1'b0;
  logic signed [DW-1:0] din = '0;
  logic        [WW-1:0] win_log2 = '0;
  logic signed [DW-1:0] dout;
  logic                 out_valid;
  logic                 filling;

  always #5 clk = ~clk;

  moving_average_ring #(.DATA_WIDTH(DW), .MAX_LOG2(ML), .WSEL_W(WW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .in_valid(in_valid), .din(din), .win_log2(win_log2), .out_mode(out_mode),
    .dout(dout), .out_valid(out_valid), .filling(filling)
  );

  int nvec = 0;
  int nerr = 0;
  int nstrobe = 0;

  int q[$];
  int m_win = 0;
  int m_acc = 0;
  int m_dout = 0;
  bit m_v = 1'b0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_win = 0; m_acc = 0; m_dout = 0; m_v = 1'b0;
  endfunction

  function automatic void model(input bit en, input bit clr, input bit v, input int d, input int w, input bit md);
    int cw, n, s;
    m_v = 1'b0;
    if (!en) return;
    cw = (w > ML) ? ML : w;
    if (clr || cw != m_win) begin
      m_win = cw;
      q.delete();
      m_acc = 0;
      return;
    end
    if (!v) return;
    q.push_back(d);
    if (q.size() > 64) void'(q.pop_front());
    m_acc++;
    n = 1 << m_win;
    if (m_acc < n) return;
    if (md && ((m_acc - n) % n) != 0) return;
    s = 0;
    for (int i = 0; i < n; i++) s += q[q.size() - 1 - i];
    m_dout = (s + n / 2) >>> m_win;
    m_v = 1'b1;
  endfunction

  task automatic step(input bit en, input bit clr, input bit v, input int d, input int w, input bit md);
    enable = en; clear = clr; in_valid = v; din = DW'(d); win_log2 = WW'(w); out_mode = md;
    @(posedge clk);
    model(en, clr, v, d, w, md);
    #1;
    if (out_valid === 1'b1) nstrobe++;
    chk("out_valid", out_valid, m_v);
    chk("dout", dout, m_dout);
    chk("filling", filling, (m_acc < (1 << m_win)));
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_dout", dout, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_filling", filling, 1);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    int vals[5];
    int w, d;
    bit en, clr, v, md;
    logic signed [DW-1:0] rv;

    #12;
    chk("rst_dout", dout, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_filling", filling, 1);
    @(negedge clk) rst_n = 1'b1;

    // N = 4, every output
    vals = '{4, 8, 12, 16, 20};
    step(1, 0, 0, 0, 2, 0);
    nstrobe = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 1, vals[i], 2, 0);
      if (i == 3) chk("r032_dout4", dout, 10);
    end
    chk("r032_dout5", dout, 14);
    chk("r032_strobes", nstrobe, 2);

    // N = 8, decimated
    step(1, 0, 0, 0, 3, 1);
    nstrobe = 0;
    repeat (16) step(1, 0, 1, 100, 3, 1);
    chk("r033_strobes", nstrobe, 2);
    chk("r033_dout", dout, 100);

    // N = 2, negative rounding
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 1, -3, 1, 0);
    step(1, 0, 1, -4, 1, 0);
    chk("r034_a", dout, -3);
    step(1, 0, 1, -4, 1, 0);
    step(1, 0, 1, -5, 1, 0);
    chk("r034_b", dout, -4);

    // N = 16 ramp with idle and disabled cycles interleaved
    step(1, 0, 0, 0, 4, 0);
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) begin
        if ($urandom_range(0, 1) == 0) step(1, 0, 0, 777, 4, 0);
        else step(0, 1, 1, 555, $urandom_range(0, 7), 1);
      end
      step(1, 0, 1, i, 4, 0);
    end
    chk("r035_dout", dout, 32);

    // window change flushes and discards the sample
    step(1, 0, 0, 0, 2, 0);
    for (int i = 1; i <= 4; i++) step(1, 0, 1, i, 2, 0);
    step(1, 0, 1, 99, 1, 0);
    chk("r036_nostrobe", out_valid, 0);
    chk("r036_filling", filling, 1);
    step(1, 0, 1, 10, 1, 0);
    step(1, 0, 1, 20, 1, 0);
    chk("r036_dout", dout, 15);
    step(1, 0, 1, 5, 7, 0);
    nstrobe = 0;
    for (int i = 0; i < 15; i++) step(1, 0, 1, 3 * i, 7, 0);
    chk("r036_clamp_pre", nstrobe, 0);
    step(1, 0, 1, 1000, 7, 0);
    chk("r036_clamp_post", nstrobe, 1);

    // clear in FILL, then reset in RUN
    step(1, 0, 0, 0, 3, 0);
    repeat (3) step(1, 0, 1, 50, 3, 0);
    step(1, 1, 1, 60, 3, 0);
    chk("r037_clr_fill", filling, 1);
    nstrobe = 0;
    for (int i = 0; i < 7; i++) step(1, 0, 1, i - 3, 3, 0);
    chk("r037_clr_pre", nstrobe, 0);
    step(1, 0, 1, 40, 3, 0);
    chk("r037_clr_post", nstrobe, 1);
    repeat (3) step(1, 0, 1, 70, 3, 0);
    do_reset();
    step(1, 0, 0, 0, 3, 0);
    nstrobe = 0;
    for (int i = 0; i < 7; i++) step(1, 0, 1, 11, 3, 0);
    chk("r037_rst_pre", nstrobe, 0);
    step(1, 0, 1, 19, 3, 0);
    chk("r037_rst_post", nstrobe, 1);

    // randomized traffic
    w = 3; md = 1'b0;
    repeat (800) begin
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 49) == 0);
      v   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 59) == 0) w = $urandom_range(0, 7);
      if (m_acc == 0) md = 1'($urandom_range(0, 1));
      rv = DW'($urandom);
      d = int'(rv);
      step(en, clr, v, d, w, md);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
